nibble_serial_add_ctrl: RTL
===========================

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4: number of 4-bit slices per operation; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, W bits: operand A, captured on start acceptance.
REQ-006 The block SHALL have port b, input, W bits: operand B, captured on start acceptance.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, captured on start acceptance.
REQ-008 The block SHALL have port sub, input, 1 bit: subtract select, captured on start acceptance; used only when SUB_EN is defined.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-011 The block SHALL have port sum, output, W bits: registered result.
REQ-012 The block SHALL have port cout, output, 1 bit: registered final carry-out.

Function
REQ-013 The block SHALL perform all arithmetic through exactly one instance of the team 4-bit ripple-carry adder (RCA_4bit), one nibble per cycle, LSB nibble first.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the block SHALL capture a, b, cin and sub, clear the nibble index and carry register, and go to RUN.
REQ-016 In IDLE with start=0, the block SHALL hold all outputs.
REQ-017 Each RUN cycle, the block SHALL present nibble[idx] of the captured operands and the carry register to the adder; it SHALL write the adder sum into sum[4*idx+3:4*idx] and the adder carry-out into the carry register.
REQ-018 On the first RUN cycle, the adder carry-in SHALL be the captured cin; on later cycles it SHALL be the carry register.
REQ-019 When idx = NIBBLES-1, the block SHALL write the adder carry-out to cout and go to DONE; otherwise it SHALL increment idx.
REQ-020 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-021 Latency: start accepted at edge T SHALL give done=1 during the cycle following edge T+NIBBLES.
REQ-022 start asserted in RUN or DONE SHALL be ignored: no capture, no restart, no queuing.
REQ-023 sum and cout SHALL hold their last values from DONE until the next accepted start.
REQ-024 sum nibbles not yet processed in the current operation SHALL keep their previous values.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, idx=0, carry register=0, sum=0, cout=0, busy=0 and done=0.
REQ-026 A reset during RUN SHALL abort the operation; no done pulse SHALL follow, and the next start SHALL begin a fresh operation.

Configuration
REQ-027 With macro SUB_EN defined and captured sub=1, the block SHALL use ~b as the B operand and force the first-nibble carry-in to 1 (cin ignored), so sum = a - b and cout = 1 means no borrow.
REQ-028 With SUB_EN defined and sub=0, or with SUB_EN undefined, the block SHALL perform addition only; the sub port SHALL be ignored and SHALL drive no logic.

Verification
REQ-029 A bench SHALL apply NIBBLES=4, a=0x1234, b=0x4321, cin=0, start for one cycle, and SHALL check sum=0x5555, cout=0, and busy for 4 cycles followed by a single done pulse.
REQ-030 A bench SHALL apply a=0xFFFF, b=0x0001, cin=0, and SHALL check sum=0x0000 and cout=1, confirming carry propagation across all nibbles.
REQ-031 A bench SHALL apply a=0x00F0, b=0x0010, cin=1, and SHALL check sum=0x0101 and cout=0.
REQ-032 A bench SHALL pulse start with new operands while busy=1, and SHALL check that the original result is unchanged and that exactly one done pulse occurs.
REQ-033 A bench SHALL assert rst in the 2nd RUN cycle, and SHALL check that all outputs are 0 immediately, no done pulse occurs, and a following start with a=0x0001, b=0x0002 gives sum=0x0003.
REQ-034 A bench with SUB_EN defined SHALL apply a=0x0005, b=0x0007, sub=1, and SHALL check sum=0xFFFE and cout=0; with a=0x0007, b=0x0005, sub=1 it SHALL check sum=0x0002 and cout=1.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_add_ctrl (with helper RCA_4bit)
//  Purpose  : W-bit add, one 4-bit nibble per cycle through a single
//             ripple-carry adder. Define SUB_EN to enable a - b when sub=1.
//  Revision : 1.0  initial release
// ============================================================================

module RCA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] w_c;

    assign w_c[0] = cin;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
        assign s[gi]     = a[gi] ^ b[gi] ^ w_c[gi];
        assign w_c[gi+1] = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = w_c[4];
endmodule

module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic              r_cin;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic [W-1:0]      r_sum;
    logic              r_cout;

    logic [3:0]        w_nib_a;
    logic [3:0]        w_nib_b;
    logic              w_add_cin;
    logic [3:0]        w_nib_s;
    logic              w_nib_co;
    logic [W-1:0]      w_b_cap;
    logic              w_cin_cap;

    // Subtraction is folded into the captured operands: ~b with a forced
    // carry-in of one, so the serial datapath never needs to know about it.
`ifdef SUB_EN
    assign w_b_cap   = sub ? ~b : b;
    assign w_cin_cap = sub ? 1'b1 : cin;
`else
    logic w_unused_sub;
    assign w_unused_sub = sub;
    assign w_b_cap      = b;
    assign w_cin_cap    = cin;
`endif

    assign w_nib_a   = r_a[4*r_idx +: 4];
    assign w_nib_b   = r_b[4*r_idx +: 4];
    assign w_add_cin = (r_idx == '0) ? r_cin : r_carry;

    RCA_4bit u_rca (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (w_add_cin),
        .s    (w_nib_s),
        .cout (w_nib_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (r_idx == c_last_idx) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_cap;
                        r_cin   <= w_cin_cap;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                    end
                end
                RUN: begin
                    r_sum[4*r_idx +: 4] <= w_nib_s;
                    r_carry             <= w_nib_co;
                    if (r_idx == c_last_idx) begin
                        r_cout <= w_nib_co;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

`default_nettype wire
